fmul_result_queue: RTL and testbench

Downstream companion of the pipelined FP32 multiplier (`Top_Mul`). It captures each result/flag bundle the multiplier emits, buffers it in a FIFO, and presents it to the consumer through a valid/ready handshake. It also holds a credit counter that throttles the issue stage, because the multiplier pipeline cannot stall. It accumulates sticky IEEE exception status for the FPU status register.

---
 rtl/fpu_pkg.sv | 24 ++
 rtl/sync_fifo_core.sv | 61 ++++++
 rtl/fmul_result_queue.sv | 109 ++++++++++
 tb/tb_fmul_result_queue.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FP32 field widths, flag bit positions and the result-queue entry layout
// used by the multiplier back end.
package fpu_pkg;
    localparam int SIGN_W  = 1;
    localparam int EXP_W   = 8;
    localparam int MANT_W  = 23;
    localparam int FLAG_W  = 5;

    localparam int FLG_INV  = 4;
    localparam int FLG_OVF  = 3;
    localparam int FLG_UNF  = 2;
    localparam int FLG_INX  = 1;
    localparam int FLG_ZERO = 0;

    localparam int RESULT_W = SIGN_W + EXP_W + MANT_W;
    localparam int ENTRY_W  = RESULT_W + FLAG_W;

    typedef struct packed {
        logic              s;
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] m;
        logic [FLAG_W-1:0] flags;
    } fmul_entry_t;
endpackage

// File: rtl/sync_fifo_core.sv
// Show-ahead synchronous FIFO of multiplier result entries; full/empty are
// derived from the occupancy count rather than from pointer comparison.
module sync_fifo_core
    import fpu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  fmul_entry_t      wr_data,
    output fmul_entry_t      rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    fmul_entry_t      mem_q [DEPTH];

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Head is forced to zero when empty so the outputs read 0 after reset.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/fmul_result_queue.sv
// Result queue behind the non-stallable FP32 multiplier: buffers result/flag
// bundles, issues credits to the issue stage and keeps sticky exception status.
module fmul_result_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic                in_valid,
    input  logic                Sz,
    input  logic [EXP_W-1:0]    Ez,
    input  logic [MANT_W-1:0]   Mz,
    input  logic                invalid_flagex,
    input  logic                overflow_flagex,
    input  logic                underflow_flagex,
    input  logic                inexact_flagex,
    input  logic                zero_flagex,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RESULT_W-1:0] out_result,
    output logic [FLAG_W-1:0]   out_flags,
    output logic [CNT_W-1:0]    count,
    output logic [FLAG_W-1:0]   status_flags,
    input  logic                status_clr,
    output logic                drop_err,
    output logic                proto_err
);
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [FLAG_W-1:0] status_q, status_d;
    logic              drop_err_q, drop_err_d;
    logic              proto_err_q, proto_err_d;

    logic              full, empty, push, pop, fire_issue;
    logic [CNT_W:0]    credit_used;
    logic [FLAG_W-1:0] in_flags;
    fmul_entry_t       wr_entry, rd_entry;

    assign in_flags = {invalid_flagex, overflow_flagex, underflow_flagex,
                       inexact_flagex, zero_flagex};
    assign wr_entry = {Sz, Ez, Mz, in_flags};

    // Credits cover both buffered entries and results still inside the pipe.
    assign credit_used = {1'b0, count} + {1'b0, inflight_q};
    assign issue_ready = (credit_used < (CNT_W+1)'(DEPTH));
    assign fire_issue  = issue_valid & issue_ready;

    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign push      = in_valid & (~full | pop);

    sync_fifo_core #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign out_result   = {rd_entry.s, rd_entry.e, rd_entry.m};
    assign out_flags    = rd_entry.flags;
    assign status_flags = status_q;
    assign drop_err     = drop_err_q;
    assign proto_err    = proto_err_q;

    always_comb begin
        inflight_d  = inflight_q;
        status_d    = status_q;
        drop_err_d  = drop_err_q;
        proto_err_d = proto_err_q;

        if (fire_issue && !in_valid) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!fire_issue && in_valid && inflight_q != '0) begin
            inflight_d = inflight_q - CNT_W'(1);
        end

        if (in_valid && inflight_q == '0) proto_err_d = 1'b1;
        if (in_valid && full && !pop)     drop_err_d  = 1'b1;

        // A clear coinciding with new flags keeps the new events.
        if (in_valid) begin
            status_d = status_clr ? in_flags : (status_q | in_flags);
        end else if (status_clr) begin
            status_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            inflight_q  <= '0;
            status_q    <= '0;
            drop_err_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            inflight_q  <= inflight_d;
            status_q    <= status_d;
            drop_err_q  <= drop_err_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_fmul_result_queue.sv
// Bench for fmul_result_queue: directed scenarios plus random traffic, all
// checked against a queue-based reference model.
module tb_fmul_result_queue;
    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        issue_valid = 0, in_valid = 0, out_ready = 0, status_clr = 0;
    logic        Sz = 0;
    logic [7:0]  Ez = 0;
    logic [22:0] Mz = 0;
    logic        invalid_flagex = 0, overflow_flagex = 0, underflow_flagex = 0;
    logic        inexact_flagex = 0, zero_flagex = 0;
    logic        issue_ready, out_valid, drop_err, proto_err;
    logic [31:0] out_result;
    logic [4:0]  out_flags, status_flags;
    logic [4:0]  count;

    fmul_result_queue dut (
        .CLK(CLK), .RST(RST),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .in_valid(in_valid), .Sz(Sz), .Ez(Ez), .Mz(Mz),
        .invalid_flagex(invalid_flagex), .overflow_flagex(overflow_flagex),
        .underflow_flagex(underflow_flagex), .inexact_flagex(inexact_flagex),
        .zero_flagex(zero_flagex),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .count(count),
        .status_flags(status_flags), .status_clr(status_clr),
        .drop_err(drop_err), .proto_err(proto_err)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the buffer is a plain queue of {result, flags}.
    logic [36:0] mq[$];
    int          m_infl;
    logic [4:0]  m_stat;
    logic        m_drop, m_proto;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 64'(count), 64'(mq.size()));
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_result", 64'(out_result), 64'(mq[0][36:5]));
            chk("out_flags", 64'(out_flags), 64'(mq[0][4:0]));
        end else begin
            chk("head_idle", 64'({out_result, out_flags}), 64'(0));
        end
        chk("issue_ready", 64'(issue_ready), 64'((mq.size() + m_infl) < DEPTH));
        chk("status_flags", 64'(status_flags), 64'(m_stat));
        chk("drop_err", 64'(drop_err), 64'(m_drop));
        chk("proto_err", 64'(proto_err), 64'(m_proto));
    endtask

    task automatic model_step(input logic iv, input logic inv, input logic [31:0] res,
                              input logic [4:0] flg, input logic ordy, input logic clr);
        int sz = mq.size();
        bit fire = iv && ((sz + m_infl) < DEPTH);
        bit pop  = (sz > 0) && ordy;
        if (pop) void'(mq.pop_front());
        if (inv) begin
            if (sz < DEPTH || pop) mq.push_back({res, flg});
            else m_drop = 1'b1;
            m_stat = clr ? flg : (m_stat | flg);
            if (m_infl == 0) m_proto = 1'b1;
        end else if (clr) begin
            m_stat = '0;
        end
        if (fire && !inv) m_infl++;
        else if (!fire && inv && m_infl > 0) m_infl--;
    endtask

    task automatic cycle(input logic iv, input logic inv, input logic [31:0] res,
                         input logic [4:0] flg, input logic ordy, input logic clr,
                         output logic fired);
        @(negedge CLK);
        issue_valid = iv;
        in_valid    = inv;
        {Sz, Ez, Mz} = res;
        {invalid_flagex, overflow_flagex, underflow_flagex, inexact_flagex, zero_flagex} = flg;
        out_ready   = ordy;
        status_clr  = clr;
        #1;
        check_all();
        fired = iv & issue_ready;
        model_step(iv, inv, res, flg, ordy, clr);
        @(posedge CLK);
    endtask

    // Reset lands mid-cycle so the asynchronous path is what gets observed.
    task automatic do_reset();
        #2;
        RST = 1'b0;
        issue_valid = 0; in_valid = 0; out_ready = 0; status_clr = 0;
        mq.delete();
        m_infl = 0; m_stat = '0; m_drop = 0; m_proto = 0;
        #1;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_head", 64'({out_result, out_flags}), 64'(0));
        chk("rst_status", 64'({status_flags, drop_err, proto_err}), 64'(0));
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check_all();
    endtask

    initial begin
        logic f;
        int   fires;
        logic [2:0] pipe;

        do_reset();

        // Single operation: 2.0 * 3.0 = 6.0
        cycle(1, 0, 0, 0, 0, 0, f);
        cycle(0, 1, 32'h40C0_0000, 5'b00000, 0, 0, f);
        #1;
        chk("single_valid", 64'(out_valid), 64'(1));
        chk("single_result", 64'(out_result), 64'h40C0_0000);
        chk("single_count", 64'(count), 64'(1));
        cycle(0, 0, 0, 0, 1, 0, f);
        #1 chk("single_popped", 64'(count), 64'(0));

        // Sticky status
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, f);
        cycle(0, 1, 32'h7F80_0000, 5'b01010, 1, 0, f);
        cycle(0, 1, 32'h0000_0000, 5'b00001, 1, 0, f);
        #1 chk("sticky_or", 64'(status_flags), 64'(5'b01011));
        cycle(0, 1, 32'h7FC0_0000, 5'b10000, 1, 1, f);
        #1 chk("sticky_clr_new", 64'(status_flags), 64'(5'b10000));
        cycle(0, 0, 0, 0, 1, 1, f);
        #1 chk("sticky_clr", 64'(status_flags), 64'(0));
        cycle(0, 0, 0, 0, 1, 0, f);

        // Credit throttle
        fires = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 0, 0, 0, 0, f);
            fires += int'(f);
        end
        chk("throttle_fires", 64'(fires), 64'(16));
        for (int i = 0; i < 16; i++) cycle(0, 1, $urandom, 5'($urandom), 0, 0, f);
        #1;
        chk("throttle_count", 64'(count), 64'(16));
        chk("throttle_nodrop", 64'(drop_err), 64'(0));

        // Full FIFO with simultaneous pop and push
        cycle(0, 1, 32'h3F80_0000, 5'b00010, 1, 0, f);
        #1;
        chk("full_simul_count", 64'(count), 64'(16));
        chk("full_simul_nodrop", 64'(drop_err), 64'(0));

        // Forced drop
        cycle(0, 1, 32'h1234_5678, 5'b00100, 0, 0, f);
        #1;
        chk("drop_err", 64'(drop_err), 64'(1));
        chk("drop_count", 64'(count), 64'(16));
        cycle(0, 0, 0, 0, 0, 0, f);
        for (int i = 0; i < 17; i++) cycle(0, 0, 0, 0, 1, 0, f);

        // Reset mid-stream with count=5, inflight=3
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 0, 0, f);
        for (int i = 0; i < 5; i++) cycle(0, 1, $urandom, 5'($urandom), 0, 0, f);
        #1 chk("pre_reset_count", 64'(count), 64'(5));
        do_reset();
        chk("post_reset_ready", 64'(issue_ready), 64'(1));
        chk("post_reset_proto", 64'(proto_err), 64'(0));

        // Well-behaved traffic: in_valid follows fires by three cycles.
        pipe = '0;
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom), pipe[2], $urandom, 5'($urandom),
                  ($urandom % 4) != 0, ($urandom % 16) == 0, f);
            pipe = {pipe[1:0], f};
        end
        #1;
        chk("disciplined_nodrop", 64'(drop_err), 64'(0));
        chk("disciplined_noproto", 64'(proto_err), 64'(0));

        // Unconstrained traffic, including drops and protocol errors.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom), ($urandom % 3) != 0, $urandom, 5'($urandom),
                  ($urandom % 3) == 0, ($urandom % 20) == 0, f);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
